// File: rtl/pattern_gen_pkg.sv
// Shared types for the multi-channel pattern generator: mode encoding, FSM states, pass counter width.
// Pure declarations, no logic.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_TABLE = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int PASS_CNT_W = 16;

endpackage

// File: rtl/pattern_table_ram.sv
// Pattern table: register array, one write port, one asynchronous read port with write-through bypass.
// Read is combinational; writes land on the rising edge and never stall.
module pattern_table_ram #(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 3,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;

    assign w_wr_ok = wr_en_i && (int'(wr_addr_i) < DEPTH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WIDTH'(i);
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // A same-cycle write to the address being read is forwarded so the new data is used.
    assign rd_data_o = (w_wr_ok && (wr_addr_i == rd_addr_i)) ? wr_data_i : r_mem[rd_addr_i];

endmodule

// File: rtl/multi_pattern_generator.sv
// Replicated-lane test pattern generator (table / count / walking-one) with hold, wrap pulse and pass counter.
// One cycle from start/position to registered data_o; hold_i freezes position and outputs.
module multi_pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter  int                   IO_SIZE_G     = 3,
    parameter  int                   NUM_CH_G      = 3,
    parameter  int                   SEQ_DEPTH_G   = 16,
    parameter  logic [IO_SIZE_G-1:0] IDLE_VAL_G    = '0,
    parameter  logic [IO_SIZE_G-1:0] DEFAULT_VAL_G = '1,
    localparam int                   ADDR_W        = $clog2(SEQ_DEPTH_G),
    localparam int                   LEN_W         = ADDR_W + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic                               stop_i,
    input  logic                               hold_i,
    input  logic [1:0]                         mode_i,
    input  logic [LEN_W-1:0]                   seq_len_i,
    input  logic                               wr_en_i,
    input  logic [ADDR_W-1:0]                  wr_addr_i,
    input  logic [IO_SIZE_G-1:0]               wr_data_i,
    input  logic [NUM_CH_G-1:0]                inj_mask_i,
    output logic [NUM_CH_G-1:0][IO_SIZE_G-1:0] data_o,
    output logic                               valid_o,
    output logic                               wrap_o,
    output logic [PASS_CNT_W-1:0]              pass_cnt_o
);

    state_e                r_state, w_state_nxt;
    mode_e                 r_mode, w_cur_mode;
    logic [LEN_W-1:0]      r_len, w_cur_len, w_len_in;
    logic [ADDR_W-1:0]     r_pos, w_cur_pos, w_pos_nxt;
    logic                  w_start, w_adv, w_stop, w_last;
    logic [IO_SIZE_G-1:0]  w_tab_dat, w_elem;
    logic [PASS_CNT_W-1:0] w_pass_base, w_pass_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start_i && !stop_i) w_state_nxt = ST_RUN;
            ST_RUN:  if (stop_i) w_state_nxt = ST_IDLE;
                     else if (hold_i) w_state_nxt = ST_HOLD;
            ST_HOLD: if (stop_i) w_state_nxt = ST_IDLE;
                     else if (!hold_i) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Every cycle that ends in RUN registers a new element, including the start cycle itself.
    always_comb begin
        w_start = (r_state == ST_IDLE) && (w_state_nxt == ST_RUN);
        w_adv   = (w_state_nxt == ST_RUN);
        w_stop  = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
    end

    always_comb begin
        w_len_in = seq_len_i;
        if (seq_len_i == '0)                        w_len_in = LEN_W'(1);
        else if (int'(seq_len_i) > SEQ_DEPTH_G)     w_len_in = LEN_W'(SEQ_DEPTH_G);
    end

    assign w_cur_mode = w_start ? mode_e'(mode_i) : r_mode;
    assign w_cur_len  = w_start ? w_len_in : r_len;
    assign w_cur_pos  = w_start ? '0 : r_pos;
    assign w_last     = ({1'b0, w_cur_pos} == (w_cur_len - LEN_W'(1)));
    assign w_pos_nxt  = w_last ? '0 : (w_cur_pos + ADDR_W'(1));

    pattern_table_ram #(
        .DEPTH (SEQ_DEPTH_G),
        .WIDTH (IO_SIZE_G)
    ) u_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (w_cur_pos),
        .rd_data_o (w_tab_dat)
    );

    always_comb begin
        w_elem = DEFAULT_VAL_G;
        case (w_cur_mode)
            MODE_TABLE: w_elem = w_tab_dat;
            MODE_COUNT: w_elem = IO_SIZE_G'(w_cur_pos);
            MODE_WALK:  w_elem = IO_SIZE_G'(1) << (int'(w_cur_pos) % IO_SIZE_G);
            default:    w_elem = DEFAULT_VAL_G;
        endcase
    end

    assign w_pass_base = w_start ? '0 : pass_cnt_o;
    assign w_pass_nxt  = (w_last && (w_pass_base != '1)) ? (w_pass_base + PASS_CNT_W'(1)) : w_pass_base;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode     <= MODE_TABLE;
            r_len      <= LEN_W'(1);
            r_pos      <= '0;
            data_o     <= {NUM_CH_G{IDLE_VAL_G}};
            valid_o    <= 1'b0;
            wrap_o     <= 1'b0;
            pass_cnt_o <= '0;
        end else if (w_adv) begin
            r_mode     <= w_cur_mode;
            r_len      <= w_cur_len;
            r_pos      <= w_pos_nxt;
            for (int c = 0; c < NUM_CH_G; c++) begin
                data_o[c] <= w_elem ^ IO_SIZE_G'(inj_mask_i[c]);
            end
            valid_o    <= 1'b1;
            wrap_o     <= w_last;
            pass_cnt_o <= w_pass_nxt;
        end else begin
            wrap_o <= 1'b0;
            if (w_stop) begin
                data_o  <= {NUM_CH_G{IDLE_VAL_G}};
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_pattern_generator.sv
// Directed bench for multi_pattern_generator with an element-count reference model and literal expectations.
module tb_multi_pattern_generator;

    localparam int NCH   = 3;
    localparam int DEPTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             hold_i = 1'b0;
    logic [1:0]       mode_i = 2'd0;
    logic [4:0]       seq_len_i = 5'd0;
    logic             wr_en_i = 1'b0;
    logic [3:0]       wr_addr_i = 4'd0;
    logic [2:0]       wr_data_i = 3'd0;
    logic [2:0]       inj_mask_i = 3'd0;
    logic [2:0][2:0]  data_o;
    logic             valid_o;
    logic             wrap_o;
    logic [15:0]      pass_cnt_o;

    always #5 clk_i = ~clk_i;

    multi_pattern_generator dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .hold_i     (hold_i),
        .mode_i     (mode_i),
        .seq_len_i  (seq_len_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .inj_mask_i (inj_mask_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .wrap_o     (wrap_o),
        .pass_cnt_o (pass_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: elements are numbered from the start; position is element index mod len.
    logic [2:0] m_tab [DEPTH];
    bit         m_act;
    int         m_mode, m_len, m_k, m_pass;
    logic [2:0] m_data [NCH];
    logic       m_valid, m_wrap;

    task automatic emit();
        int pos, v;
        pos = m_k % m_len;
        case (m_mode)
            0:       v = int'(m_tab[pos]);
            1:       v = pos % 8;
            2:       v = 1 << (pos % 3);
            default: v = 7;
        endcase
        for (int c = 0; c < NCH; c++) m_data[c] = 3'(v) ^ {2'b00, inj_mask_i[c]};
        m_valid = 1'b1;
        m_wrap  = (pos == m_len - 1);
        if (m_wrap && m_pass < 65535) m_pass++;
        m_k++;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) m_tab[i] = 3'(i % 8);
            for (int c = 0; c < NCH; c++) m_data[c] = 3'd0;
            m_act = 0; m_k = 0; m_pass = 0; m_mode = 0; m_len = 1;
            m_valid = 1'b0; m_wrap = 1'b0;
        end else begin
            if (wr_en_i) m_tab[wr_addr_i] = wr_data_i;
            m_wrap = 1'b0;
            if (!m_act) begin
                if (start_i && !stop_i) begin
                    m_act  = 1;
                    m_mode = int'(mode_i);
                    m_len  = (seq_len_i == 0) ? 1 : ((seq_len_i > 16) ? 16 : int'(seq_len_i));
                    m_k    = 0;
                    m_pass = 0;
                    emit();
                end
            end else if (stop_i) begin
                m_act   = 0;
                m_valid = 1'b0;
                for (int c = 0; c < NCH; c++) m_data[c] = 3'd0;
            end else if (!hold_i) begin
                emit();
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) chk($sformatf("model data ch%0d", c), data_o[c], m_data[c]);
            chk("model valid", valid_o, m_valid);
            chk("model wrap", wrap_o, m_wrap);
            chk("model pass", pass_cnt_o, m_pass);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Returns at the negedge where the first element is visible.
    task automatic start_run(input logic [1:0] m, input logic [4:0] l);
        mode_i = m; seq_len_i = l; start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic stop_run();
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
    endtask

    int got_d [20];
    int got_w [20];
    int got_p [20];

    task automatic record(input int n);
        for (int i = 1; i <= n; i++) begin
            got_d[i] = int'(data_o[0]);
            got_w[i] = int'(wrap_o);
            got_p[i] = int'(pass_cnt_o);
            step(1);
        end
    endtask

    logic [2:0] tv    [4] = '{3'd5, 3'd2, 3'd7, 3'd1};
    int         e_tab [6] = '{5, 2, 7, 1, 5, 2};
    int         e_cnt [6] = '{0, 1, 2, 3, 4, 0};
    int         e_wlk [6] = '{1, 2, 4, 1, 2, 1};

    initial begin
        step(2);
        chk("reset data", data_o, 0);
        chk("reset valid", valid_o, 0);
        chk("reset wrap", wrap_o, 0);
        chk("reset pass", pass_cnt_o, 0);
        rst_ni = 1'b1;
        chk_en = 1;
        step(2);

        for (int i = 0; i < 4; i++) begin
            wr_en_i = 1'b1; wr_addr_i = 4'(i); wr_data_i = tv[i];
            step(1);
        end
        wr_en_i = 1'b0;
        start_run(2'd0, 5'd4);
        record(8);
        for (int i = 1; i <= 6; i++) chk($sformatf("table elem %0d", i), got_d[i], e_tab[i-1]);
        for (int i = 1; i <= 8; i++) chk($sformatf("table wrap c%0d", i), got_w[i], (i == 4 || i == 8) ? 1 : 0);
        chk("table pass after 2nd wrap", got_p[8], 2);
        stop_run();
        chk("stop data", data_o, 0);
        chk("stop valid", valid_o, 0);
        chk("stop keeps pass", pass_cnt_o, 2);

        start_run(2'd1, 5'd5);
        record(6);
        for (int i = 1; i <= 6; i++) chk($sformatf("count elem %0d", i), got_d[i], e_cnt[i-1]);
        stop_run();

        start_run(2'd2, 5'd5);
        record(6);
        for (int i = 1; i <= 6; i++) chk($sformatf("walk elem %0d", i), got_d[i], e_wlk[i-1]);
        stop_run();

        start_run(2'd1, 5'd5);
        step(1);
        chk("hold pre", data_o[0], 1);
        hold_i = 1'b1;
        step(3);
        chk("hold frozen data", data_o[0], 1);
        chk("hold frozen valid", valid_o, 1);
        hold_i = 1'b0;
        step(1);
        chk("hold resume", data_o[0], 2);
        step(1);
        chk("hold resume next", data_o[0], 3);
        stop_run();

        start_i = 1'b1; stop_i = 1'b1;
        step(1);
        start_i = 1'b0; stop_i = 1'b0;
        chk("start+stop valid", valid_o, 0);
        chk("start+stop data", data_o, 0);
        step(1);
        chk("start+stop stays idle", valid_o, 0);
        start_run(2'd1, 5'd5);
        step(2);
        chk("elem 2 before stop", data_o[0], 2);
        stop_run();
        chk("stop@2 data", data_o, 0);
        chk("stop@2 valid", valid_o, 0);
        chk("stop@2 pass", pass_cnt_o, 0);

        start_run(2'd1, 5'd5);
        step(1);
        inj_mask_i = 3'b010;
        step(1);
        inj_mask_i = 3'b000;
        chk("inj ch0", data_o[0], 2);
        chk("inj ch1", data_o[1], 3);
        chk("inj ch2", data_o[2], 2);
        step(1);
        chk("inj over ch1", data_o[1], 3);
        chk("inj over ch0", data_o[0], 3);
        stop_run();

        start_run(2'd3, 5'd4);
        chk("reserved ch0", data_o[0], 7);
        chk("reserved ch2", data_o[2], 7);
        chk("reserved valid", valid_o, 1);
        stop_run();

        wr_en_i = 1'b1; wr_addr_i = 4'd0; wr_data_i = 3'd6;
        start_run(2'd0, 5'd2);
        wr_en_i = 1'b0;
        chk("bypass write", data_o[0], 6);
        step(1);
        chk("bypass next", data_o[0], 2);
        chk("bypass wrap", wrap_o, 1);
        stop_run();

        start_run(2'd1, 5'd5);
        step(6);
        chk("pre-reset pass", pass_cnt_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async rst data", data_o, 0);
        chk("async rst valid", valid_o, 0);
        chk("async rst wrap", wrap_o, 0);
        chk("async rst pass", pass_cnt_o, 0);
        step(1);
        rst_ni = 1'b1;
        step(2);
        chk("post-reset idle", valid_o, 0);
        start_run(2'd0, 5'd16);
        record(16);
        for (int i = 1; i <= 16; i++) chk($sformatf("reset table %0d", i - 1), got_d[i], (i - 1) % 8);
        chk("len16 wrap", got_w[16], 1);
        stop_run();

        start_run(2'd1, 5'd0);
        record(3);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("len0 data c%0d", i), got_d[i], 0);
            chk($sformatf("len0 wrap c%0d", i), got_w[i], 1);
        end
        chk("len0 pass", got_p[3], 3);
        stop_run();

        start_run(2'd1, 5'd20);
        record(17);
        chk("len20 no wrap c15", got_w[15], 0);
        chk("len20 wrap c16", got_w[16], 1);
        chk("len20 elem c16", got_d[16], 7);
        chk("len20 restart c17", got_d[17], 0);
        chk("len20 pass", got_p[17], 1);
        stop_run();

        step(2);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
